// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Icache/dcache arbiter for one single-ported RAM; dcache priority,
//            atomic dcache bursts, anti-starvation. Option macro: ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int BLK_WORDS  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_wait
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       igrants,
    output logic [15:0]       dgrants,
    output logic [15:0]       conflicts
`endif
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_GRANT_I    = 2'd1;
    localparam logic [1:0] c_GRANT_D    = 2'd2;
    localparam logic [3:0] c_LAST_BEAT  = 4'(BLK_WORDS - 1);
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic [3:0] r_beat;
    logic [3:0] r_starve;
    logic       w_dreq;
    logic       w_starved;
    logic       w_d_entry;
    logic       w_d_exit;

    assign w_dreq    = dREN | dWEN;
    assign w_starved = iREN && (r_starve == c_STARVE_MAX);
    assign w_d_entry = (r_state == c_IDLE) && (w_next == c_GRANT_D);
    assign w_d_exit  = (r_state == c_GRANT_D) && (w_next != c_GRANT_D);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every grant returns to IDLE, which gives the mandatory turnaround cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_dreq && !w_starved) begin
                    w_next = c_GRANT_D;
                end else if (iREN) begin
                    w_next = c_GRANT_I;
                end
            end
            c_GRANT_D: begin
                if (!w_dreq || (!ram_wait && (r_beat == c_LAST_BEAT))) begin
                    w_next = c_IDLE;
                end
            end
            c_GRANT_I: begin
                if (!iREN || !ram_wait) begin
                    w_next = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            c_GRANT_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ram_wait;
                dload    = ramload;
            end
            c_GRANT_I: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = ram_wait;
                iload   = ramload;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || w_d_exit) begin
            r_beat <= '0;
        end else if ((r_state == c_GRANT_D) && !ram_wait) begin
            r_beat <= r_beat + 4'd1;
        end
    end

    // Starvation is judged on iREN at the moment the dcache wins the grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve <= '0;
        end else if (w_d_entry) begin
            if (!iREN) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 4'd1;
            end
        end else if ((r_state == c_GRANT_I) && iREN && !ram_wait) begin
            r_starve <= '0;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_igrants;
    logic [15:0] r_dgrants;
    logic [15:0] r_conflicts;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_igrants   <= '0;
            r_dgrants   <= '0;
            r_conflicts <= '0;
        end else begin
            if ((r_state == c_IDLE) && (w_next == c_GRANT_I)) begin
                r_igrants <= r_igrants + 16'd1;
            end
            if (w_d_entry) begin
                r_dgrants <= r_dgrants + 16'd1;
            end
            if ((r_state == c_IDLE) && iREN && w_dreq) begin
                r_conflicts <= r_conflicts + 16'd1;
            end
        end
    end

    assign igrants   = r_igrants;
    assign dgrants   = r_dgrants;
    assign conflicts = r_conflicts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scoreboard bench for mem_arbiter with a 2-cycle RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic        iwait, dwait, ramREN, ramWEN, ram_wait;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
`ifdef ARB_STATS_EN
    logic [15:0] igrants, dgrants, conflicts;
`endif

    mem_arbiter #(.WORD_W(32), .BLK_WORDS(2), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_wait(ram_wait)
`ifdef ARB_STATS_EN
        , .igrants(igrants), .dgrants(dgrants), .conflicts(conflicts)
`endif
    );

    always #5 CLK = ~CLK;

    // RAM model: an access completes on its LAT-th strobed cycle.
    bit [1:0] r_cnt;
    logic     w_strobe;
    assign w_strobe = ramREN | ramWEN;
    assign ram_wait = !(w_strobe && (r_cnt == 2'(LAT - 1)));
    assign ramload  = {16'hA5A5, ramaddr[15:0]};
    always @(posedge CLK) begin
        if (!w_strobe || !ram_wait) r_cnt <= 2'd0;
        else                        r_cnt <= r_cnt + 2'd1;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 = icache, 1 = dcache
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    task automatic push(input int kind, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input int c);
        exp_t e;
        e.kind = kind; e.we = we; e.addr = a; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic handle(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            check("unexpected_completion_kind", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = q.pop_front();
            check("completion_kind", 32'(kind), 32'(e.kind));
            check("completion_cycle", 32'(cyc), 32'(e.cyc));
            check("completion_addr", ramaddr, e.addr);
            if (kind == 0) begin
                check("iload", iload, e.data);
                check("i_ramREN", {31'd0, ramREN}, 32'd1);
            end else if (e.we) begin
                check("write_data", ramstore, e.data);
                check("d_ramWEN", {31'd0, ramWEN}, 32'd1);
            end else begin
                check("dload", dload, e.data);
                check("d_ramREN", {31'd0, ramREN}, 32'd1);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever a wait line drops.
    always @(negedge CLK) begin
        if (iwait === 1'b0 && dwait === 1'b0)
            check("both_waits_low", 32'd1, 32'd0);
        else if (iwait === 1'b0) handle(0);
        else if (dwait === 1'b0) handle(1);
    end

    task automatic go();
        @(posedge CLK);
        #1;
    endtask

    // Contended round: 2-beat dcache burst first, then the icache read.
    task automatic round(input logic [31:0] da, input logic [31:0] ia, input logic we);
        int t;
        go();
        t = cyc;
        dREN = ~we; dWEN = we; daddr = da; dstore = da ^ 32'h5A5A_0000;
        iREN = 1'b1; iaddr = ia;
        push(1, we, da,        we ? (da ^ 32'h5A5A_0000) : rd(da), t + 2);
        push(1, we, da + 32'd4, we ? ((da + 32'd4) ^ 32'h5A5A_0000) : rd(da + 32'd4), t + 4);
        push(0, 1'b0, ia, rd(ia), t + 7);
        repeat (3) go();
        daddr = da + 32'd4; dstore = (da + 32'd4) ^ 32'h5A5A_0000;
        repeat (2) go();
        dREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK);
        check("round_turnaround_ramREN", {31'd0, ramREN}, 32'd0);
        repeat (3) go();
        iREN = 1'b0;
    endtask

    initial begin
        int t;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset values
        repeat (3) go();
        @(negedge CLK);
        check("rst_iwait", {31'd0, iwait}, 32'd1);
        check("rst_dwait", {31'd0, dwait}, 32'd1);
        check("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        go(); RST = 1'b0;

        // Single icache read, 1-cycle arbitration latency
        go(); t = cyc;
        iREN = 1'b1; iaddr = 32'h40;
        push(0, 1'b0, 32'h40, rd(32'h40), t + 2);
        @(negedge CLK);
        check("t1_idle_ramREN", {31'd0, ramREN}, 32'd0);
        go(); @(negedge CLK);
        check("t1_grant_ramREN", {31'd0, ramREN}, 32'd1);
        check("t1_grant_ramaddr", ramaddr, 32'h40);
        check("t1_grant_iwait", {31'd0, iwait}, 32'd1);
        go(); go(); iREN = 1'b0;
        @(negedge CLK);
        check("t1_after_ramREN", {31'd0, ramREN}, 32'd0);

        // Simultaneous dWEN + iREN: dcache write burst wins, icache after turnaround
        go(); t = cyc;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'h11; iREN = 1'b1; iaddr = 32'h80;
        push(1, 1'b1, 32'h100, 32'h11, t + 2);
        push(1, 1'b1, 32'h104, 32'h22, t + 4);
        push(0, 1'b0, 32'h80, rd(32'h80), t + 7);
        go(); @(negedge CLK);
        check("t2_ramWEN", {31'd0, ramWEN}, 32'd1);
        check("t2_ramREN", {31'd0, ramREN}, 32'd0);
        check("t2_iwait", {31'd0, iwait}, 32'd1);
        go(); go(); daddr = 32'h104; dstore = 32'h22;
        go(); go(); dWEN = 1'b0;
        @(negedge CLK);
        check("t2_turnaround_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        check("t2_turnaround_iwait", {31'd0, iwait}, 32'd1);
        go(); go(); go(); iREN = 1'b0;

        // Starvation: four dcache grants, then icache despite dREN
        go(); t = cyc;
        dREN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h300;
        for (int g = 0; g < 4; g++) begin
            push(1, 1'b0, 32'h200, rd(32'h200), t + 5 * g + 2);
            push(1, 1'b0, 32'h200, rd(32'h200), t + 5 * g + 4);
        end
        push(0, 1'b0, 32'h300, rd(32'h300), t + 22);
        for (int k = 1; k <= 23; k++) begin
            go();
            if (k == 21) begin
                @(negedge CLK);
                check("t3_forced_i_ramaddr", ramaddr, 32'h300);
                check("t3_forced_i_dwait", {31'd0, dwait}, 32'd1);
            end
        end
        dREN = 1'b0; iREN = 1'b0;

        // Starve counter cleared: contended round again goes dcache first
        round(32'h500, 32'h600, 1'b0);

        // Partial burst: dREN dropped after first beat
        go(); t = cyc;
        dREN = 1'b1; daddr = 32'h400;
        push(1, 1'b0, 32'h400, rd(32'h400), t + 2);
        go(); go(); go(); dREN = 1'b0;
        @(negedge CLK);
        check("t4_drop_ramREN", {31'd0, ramREN}, 32'd0);
        go(); @(negedge CLK);
        check("t4_idle_ramREN", {31'd0, ramREN}, 32'd0);
        check("t4_idle_dwait", {31'd0, dwait}, 32'd1);

        // Beat counter restarted: next burst is a full two beats
        go(); t = cyc;
        dREN = 1'b1; daddr = 32'h440;
        push(1, 1'b0, 32'h440, rd(32'h440), t + 2);
        push(1, 1'b0, 32'h444, rd(32'h444), t + 4);
        repeat (3) go(); daddr = 32'h444;
        repeat (2) go(); dREN = 1'b0;
        @(negedge CLK);
        check("t4b_done_ramREN", {31'd0, ramREN}, 32'd0);

        // Reset in the middle of a dcache beat
        go(); go(); t = cyc;
        dWEN = 1'b1; daddr = 32'h700; dstore = 32'h1;
        go(); RST = 1'b1;
        @(negedge CLK);
        check("t5_pre_ramWEN", {31'd0, ramWEN}, 32'd1);
        check("t5_pre_dwait", {31'd0, dwait}, 32'd1);
        go(); @(negedge CLK);
        check("t5_rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("t5_rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("t5_rst_ramaddr", ramaddr, 32'd0);
        check("t5_rst_dwait", {31'd0, dwait}, 32'd1);
        go(); RST = 1'b0; dWEN = 1'b0;

        // Three contended rounds
        round(32'h800, 32'h900, 1'b1);
        round(32'h810, 32'h910, 1'b0);
        round(32'h820, 32'h920, 1'b1);
`ifdef ARB_STATS_EN
        @(negedge CLK);
        check("stats_dgrants", {16'd0, dgrants}, 32'd3);
        check("stats_igrants", {16'd0, igrants}, 32'd3);
        check("stats_conflicts", {16'd0, conflicts}, 32'd3);
`endif

        repeat (5) go();
        check("scoreboard_leftover", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
